// File: rtl/accum_window_pkg.sv
// Shared types and helpers for the windowed accumulator stage.
package accum_window_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int WINDOW_DEF = 4;
  localparam int CNT_W      = clog2(WINDOW_DEF);

endpackage

// File: rtl/acc_add_sat.sv
// Combinational ACC_W-bit adder with carry-out and optional clamp to all-ones.
module acc_add_sat #(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             sat,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] full;

  assign full  = {1'b0, a} + {1'b0, b};
  assign carry = full[ACC_W];
  // A clamped accumulator re-carries on any nonzero add, so it stays pinned.
  assign sum   = (sat && carry) ? '1 : full[ACC_W-1:0];

endmodule

// File: rtl/accum_window_stage.sv
// Sums WINDOW accepted samples and presents the total through a registered
// valid/ready handshake; o_A toggles once per completed window.
module accum_window_stage
  import accum_window_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 8,
  parameter int WINDOW   = WINDOW_DEF,
  parameter int SATURATE = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [ACC_W-1:0]  o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_ovf,
  output logic              o_A
);

  localparam int                  CNT_WIDTH = clog2(WINDOW);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(WINDOW - 1);

  state_t               state;
  logic [ACC_W-1:0]     acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 ovf_acc;
  logic                 accept;
  logic [ACC_W-1:0]     add_sum;
  logic                 add_carry;

  assign accept = i_valid & o_ready;

  acc_add_sat #(
    .ACC_W(ACC_W)
  ) u_add (
    .a    (acc),
    .b    (ACC_W'(i_data)),
    .sat  (SATURATE != 0),
    .sum  (add_sum),
    .carry(add_carry)
  );

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values; later assignments in the block override earlier.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= ACCUM;
      acc     <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_ovf   <= 1'b0;
      o_A     <= 1'b0;
      o_ready <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          o_ready <= 1'b1;
          if (accept) begin
            if (cnt == LAST_CNT) begin
              o_data  <= add_sum;
              o_ovf   <= ovf_acc | add_carry;
              o_valid <= 1'b1;
              o_A     <= ~o_A;
              acc     <= '0;
              cnt     <= '0;
              ovf_acc <= 1'b0;
              o_ready <= 1'b0;
              state   <= HOLD;
            end else begin
              acc     <= add_sum;
              cnt     <= cnt + CNT_WIDTH'(1);
              ovf_acc <= ovf_acc | add_carry;
            end
          end
        end
        HOLD: begin
          // Output is frozen until downstream takes it; inputs are refused.
          if (o_valid && i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_window_stage.sv
// Self-checking bench: a wrapping and a saturating instance share stimulus and
// are compared against a queue-based window model.
module tb_accum_window_stage;

  localparam int WINDOW = 4;
  localparam int MAXV   = 255;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [7:0] i_data = '0;
  logic       i_valid = 1'b0;
  logic       i_ready = 1'b0;

  logic       w_ready, w_valid, w_ovf, w_a;
  logic [7:0] w_data;
  logic       s_ready, s_valid, s_ovf, s_a;
  logic [7:0] s_data;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int q[$];
  bit m_ready, m_valid, m_ovf, m_a;
  int m_wrap, m_sat;

  always #5 i_clk = ~i_clk;

  accum_window_stage #(.DATA_W(8), .ACC_W(8), .WINDOW(WINDOW), .SATURATE(0)) u_wrap (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_valid(i_valid),
    .o_ready(w_ready), .o_data(w_data), .o_valid(w_valid), .i_ready(i_ready),
    .o_ovf(w_ovf), .o_A(w_a)
  );

  accum_window_stage #(.DATA_W(8), .ACC_W(8), .WINDOW(WINDOW), .SATURATE(1)) u_sat (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_valid(i_valid),
    .o_ready(s_ready), .o_data(s_data), .o_valid(s_valid), .i_ready(i_ready),
    .o_ovf(s_ovf), .o_A(s_a)
  );

  // Window-level model: collect accepted samples, sum them as integers.
  task automatic model_edge(input bit rst, input bit v, input int d, input bit r);
    int total;
    if (!rst) begin
      q.delete();
      m_ready = 0; m_valid = 0; m_ovf = 0; m_a = 0; m_wrap = 0; m_sat = 0;
    end else if (m_valid) begin
      if (r) begin m_valid = 0; m_ready = 1; end
    end else if (!m_ready) begin
      m_ready = 1;
    end else if (v) begin
      q.push_back(d);
      if (q.size() == WINDOW) begin
        total   = q.sum();
        m_wrap  = total % (MAXV + 1);
        m_sat   = (total > MAXV) ? MAXV : total;
        m_ovf   = (total > MAXV);
        m_valid = 1; m_ready = 0; m_a = ~m_a;
        q.delete();
      end
    end
  endtask

  task automatic step(input bit rst, input bit v, input int d, input bit r);
    i_rst_n = rst; i_valid = v; i_data = d[7:0]; i_ready = r;
    @(posedge i_clk);
    model_edge(rst, v, d, r);
    #1;
  endtask

  task automatic test_reset;
    step(0, 1, 99, 1);
    step(0, 1, 99, 1);
    checks++; if (w_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", w_ready); end
    checks++; if (w_valid !== 1'b0 || s_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b/%b exp=0", w_valid, s_valid); end
    checks++; if (w_data !== 8'd0 || w_ovf !== 1'b0 || w_a !== 1'b0) begin failures++; $display("FAIL reset_regs data=%0d ovf=%b a=%b exp=0/0/0", w_data, w_ovf, w_a); end
    step(1, 0, 0, 0);
    checks++; if (w_ready !== 1'b1 || s_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_rise got=%b/%b exp=1", w_ready, s_ready); end
  endtask

  task automatic test_basic;
    int samples[4] = '{10, 20, 30, 40};
    for (int i = 0; i < 4; i++) begin
      step(1, 1, samples[i], 1);
      if (i == 2) begin
        checks++; if (w_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", w_valid); end
      end
    end
    checks++; if (w_valid !== 1'b1 || w_data !== 8'd100) begin failures++; $display("FAIL basic_out valid=%b data=%0d exp=1/100", w_valid, w_data); end
    checks++; if (w_ovf !== 1'b0 || w_a !== 1'b1 || w_ready !== 1'b0) begin failures++; $display("FAIL basic_flags ovf=%b a=%b ready=%b exp=0/1/0", w_ovf, w_a, w_ready); end
    step(1, 0, 0, 1);
    checks++; if (w_valid !== 1'b0 || w_ready !== 1'b1) begin failures++; $display("FAIL basic_release valid=%b ready=%b exp=0/1", w_valid, w_ready); end
  endtask

  task automatic test_wrap;
    int a_prev;
    int s1[4] = '{200, 100, 0, 0};
    a_prev = w_a;
    for (int i = 0; i < 4; i++) step(1, 1, s1[i], 0);
    checks++; if (w_data !== 8'd44 || w_ovf !== 1'b1) begin failures++; $display("FAIL wrap_out data=%0d ovf=%b exp=44/1", w_data, w_ovf); end
    checks++; if (s_data !== 8'd255 || s_ovf !== 1'b1) begin failures++; $display("FAIL wrap_sat_out data=%0d ovf=%b exp=255/1", s_data, s_ovf); end
    checks++; if (w_a === a_prev[0]) begin failures++; $display("FAIL wrap_toggle got=%b exp=%b", w_a, ~a_prev[0]); end
    step(1, 0, 0, 1);
    a_prev = w_a;
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
    checks++; if (w_data !== 8'd4 || w_ovf !== 1'b0 || s_data !== 8'd4 || s_ovf !== 1'b0) begin failures++; $display("FAIL wrap_small data=%0d/%0d ovf=%b/%b exp=4/4 0/0", w_data, s_data, w_ovf, s_ovf); end
    checks++; if (w_a === a_prev[0]) begin failures++; $display("FAIL wrap_toggle2 got=%b exp=%b", w_a, ~a_prev[0]); end
    step(1, 0, 0, 1);
  endtask

  task automatic test_saturate;
    int s1[4] = '{200, 100, 5, 0};
    for (int i = 0; i < 4; i++) step(1, 1, s1[i], 1);
    checks++; if (s_data !== 8'd255 || s_ovf !== 1'b1) begin failures++; $display("FAIL sat_out data=%0d ovf=%b exp=255/1", s_data, s_ovf); end
    checks++; if (w_data !== 8'd49 || w_ovf !== 1'b1) begin failures++; $display("FAIL sat_wrap_ref data=%0d ovf=%b exp=49/1", w_data, w_ovf); end
    step(1, 0, 0, 1);
  endtask

  task automatic test_backpressure;
    int s1[4] = '{10, 20, 30, 40};
    for (int i = 0; i < 4; i++) step(1, 1, s1[i], 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 77, 0);
      checks++; if (w_valid !== 1'b1 || w_data !== 8'd100 || w_ready !== 1'b0) begin failures++; $display("FAIL bp_hold cyc=%0d valid=%b data=%0d ready=%b exp=1/100/0", i, w_valid, w_data, w_ready); end
    end
    step(1, 1, 77, 1);
    checks++; if (w_valid !== 1'b0 || w_ready !== 1'b1) begin failures++; $display("FAIL bp_release valid=%b ready=%b exp=0/1", w_valid, w_ready); end
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 77, 0);
      if (i == 2) begin
        checks++; if (w_valid !== 1'b0) begin failures++; $display("FAIL bp_early_valid got=%b exp=0", w_valid); end
      end
    end
    checks++; if (w_valid !== 1'b1 || w_data !== 8'd52 || s_data !== 8'd255 || w_ovf !== 1'b1) begin failures++; $display("FAIL bp_next valid=%b data=%0d/%0d ovf=%b exp=1 52/255 1", w_valid, w_data, s_data, w_ovf); end
    step(1, 0, 0, 1);
  endtask

  task automatic test_gaps;
    int outs;
    for (int k = 5; k <= 8; k++) begin
      step(1, 1, k, 0);
      if (k != 8) begin
        for (int g = 0; g < 3; g++) begin
          step(1, 0, 0, 0);
          checks++; if (w_valid !== 1'b0) begin failures++; $display("FAIL gap_valid sample=%0d got=%b exp=0", k, w_valid); end
        end
      end
    end
    checks++; if (w_valid !== 1'b1 || w_data !== 8'd26 || w_ovf !== 1'b0) begin failures++; $display("FAIL gap_out valid=%b data=%0d ovf=%b exp=1/26/0", w_valid, w_data, w_ovf); end
    outs = 0;
    for (int g = 0; g < 8; g++) begin
      step(1, 0, 0, 1);
      if (w_valid === 1'b1) outs++;
    end
    checks++; if (outs != 0) begin failures++; $display("FAIL gap_once extra=%0d exp=0", outs); end
  endtask

  task automatic test_reset_mid;
    step(1, 1, 50, 1);
    step(1, 1, 60, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    checks++; if (w_valid !== 1'b0 || w_a !== 1'b0 || w_ready !== 1'b1) begin failures++; $display("FAIL rmid_after valid=%b a=%b ready=%b exp=0/0/1", w_valid, w_a, w_ready); end
    for (int k = 1; k <= 4; k++) begin
      step(1, 1, k, 0);
      if (k == 2) begin
        checks++; if (w_valid !== 1'b0) begin failures++; $display("FAIL rmid_aborted valid=%b exp=0", w_valid); end
      end
    end
    checks++; if (w_valid !== 1'b1 || w_data !== 8'd10 || w_a !== 1'b1) begin failures++; $display("FAIL rmid_out valid=%b data=%0d a=%b exp=1/10/1", w_valid, w_data, w_a); end
    step(1, 0, 0, 1);
  endtask

  task automatic test_random;
    bit rst, v, r;
    int d;
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 99) != 0);
      v   = ($urandom_range(0, 9) < 7);
      r   = ($urandom_range(0, 1) == 1);
      d   = (n % 3 == 0) ? $urandom_range(0, 10) : $urandom_range(0, 255);
      step(rst, v, d, r);
      checks++; if (w_ready !== m_ready || s_ready !== m_ready) begin failures++; $display("FAIL rnd_ready n=%0d got=%b/%b exp=%b", n, w_ready, s_ready, m_ready); end
      checks++; if (w_valid !== m_valid || s_valid !== m_valid) begin failures++; $display("FAIL rnd_valid n=%0d got=%b/%b exp=%b", n, w_valid, s_valid, m_valid); end
      checks++; if (int'(w_data) != m_wrap || int'(s_data) != m_sat) begin failures++; $display("FAIL rnd_data n=%0d got=%0d/%0d exp=%0d/%0d", n, w_data, s_data, m_wrap, m_sat); end
      checks++; if (w_ovf !== m_ovf || s_ovf !== m_ovf) begin failures++; $display("FAIL rnd_ovf n=%0d got=%b/%b exp=%b", n, w_ovf, s_ovf, m_ovf); end
      checks++; if (w_a !== m_a || s_a !== m_a) begin failures++; $display("FAIL rnd_a n=%0d got=%b/%b exp=%b", n, w_a, s_a, m_a); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_saturate();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
